// File: rtl/adc_frontend.sv
// adc_frontend: SPI master for a 10-bit MCP3002-class ADC with DC-bias
// calibration, bias correction and noise gate, sign-magnitude output.
module adc_frontend #(
    parameter int SAMPLE_PERIOD = 833,
    parameter int SCLK_HALF     = 8,
    parameter int CAL_LOG2      = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_cal,
    input  logic [9:0] gate_thresh,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       ncs,
    output logic [9:0] raw_sample,
    output logic [9:0] offset,
    output logic       calibrating,
    output logic       sample_sign,
    output logic [9:0] sample_mag,
    output logic       sample_valid
);

    localparam int CW = $clog2(SAMPLE_PERIOD);
    localparam int DW = $clog2(SCLK_HALF);
    localparam int AW = 10 + CAL_LOG2;

    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_PERIOD - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(32 * SCLK_HALF);
    localparam logic [CW-1:0] CNT_PROC = CW'(32 * SCLK_HALF + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_HALF - 1);
    localparam logic [DW-1:0] DIV_MID  = DW'(SCLK_HALF / 2);

    // Command bits by sclk period: start, single-ended, ch0, MSB-first.
    localparam logic [3:0] CMD = 4'b1011;

    typedef enum logic {
        CAL,
        RUN
    } state_t;

    // Frame position: cnt, sclk half-period divider and half-period index.
    // The half index saturates at 32, which marks "outside the SPI burst".
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic [5:0]    hidx_q, hidx_d;
    logic          wrap;

    logic       ncs_q, sclk_q, mosi_q;
    logic [9:0] sr_q;
    logic [9:0] raw_q;
    logic       sign_q;
    logic [9:0] mag_q;
    logic       valid_q;

    state_t              state_q;
    logic                pend_q;
    logic                cal_q;
    logic [9:0]          offset_q;
    logic [AW-1:0]       acc_q;
    logic [AW-1:0]       acc_sum;
    logic [CAL_LOG2-1:0] ccnt_q;

    logic       capture;
    logic       load;
    logic       proc;
    logic       ge;
    logic [9:0] diff;
    logic       gated;
    logic       sign_c;
    logic [9:0] mag_c;

    // Next frame position; SPI lines are registered from it so they
    // line up exactly with cnt and idle asynchronously on reset.
    always_comb begin
        wrap   = (cnt_q == CNT_LAST);
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        div_d  = (wrap || div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        hidx_d = hidx_q;
        if (wrap)
            hidx_d = '0;
        else if (div_q == DIV_LAST && hidx_q != 6'd32)
            hidx_d = hidx_q + 6'd1;
    end

    // Strobes for MISO capture (rising edges 6..15), raw load and processing.
    always_comb begin
        capture = ~hidx_q[5] & hidx_q[0] & (div_q == DIV_MID) &
                  (hidx_q[4:1] >= 4'd5) & (hidx_q[4:1] <= 4'd14);
        load    = (cnt_q == CNT_LOAD);
        proc    = (cnt_q == CNT_PROC);
    end

    // Bias correction and noise gate; zero is always emitted as positive.
    always_comb begin
        ge     = (raw_q >= offset_q);
        diff   = ge ? (raw_q - offset_q) : (offset_q - raw_q);
        gated  = (diff < gate_thresh);
        sign_c = ~ge & ~gated;
        mag_c  = gated ? 10'd0 : diff;
        acc_sum = acc_q + AW'(raw_q);
    end

    // Frame counter and SPI output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            div_q  <= '0;
            hidx_q <= '0;
            ncs_q  <= 1'b1;
            sclk_q <= 1'b0;
            mosi_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            hidx_q <= hidx_d;
            ncs_q  <= hidx_d[5];
            sclk_q <= ~hidx_d[5] & hidx_d[0];
            mosi_q <= (hidx_d[5:3] == 3'd0) & CMD[hidx_d[2:1]];
        end
    end

    // MISO shift register, raw capture and sample output pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q    <= '0;
            raw_q   <= '0;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (capture)
                sr_q <= {sr_q[8:0], miso};
            if (load)
                raw_q <= sr_q;
            if (proc && state_q == RUN) begin
                sign_q <= sign_c;
                mag_q  <= mag_c;
            end
            valid_q <= proc & (state_q == RUN);
        end
    end

    // Calibration FSM: averages 2^CAL_LOG2 frames into the bias estimate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= CAL;
            pend_q   <= 1'b0;
            cal_q    <= 1'b1;
            offset_q <= 10'h200;
            acc_q    <= '0;
            ccnt_q   <= '0;
        end else if (cnt_q == '0 && pend_q) begin
            state_q <= CAL;
            pend_q  <= start_cal;
            cal_q   <= 1'b1;
            acc_q   <= '0;
            ccnt_q  <= '0;
        end else begin
            if (start_cal)
                pend_q <= 1'b1;
            if (proc && state_q == CAL) begin
                if (&ccnt_q) begin
                    offset_q <= 10'(acc_sum >> CAL_LOG2);
                    state_q  <= RUN;
                    cal_q    <= 1'b0;
                    acc_q    <= '0;
                    ccnt_q   <= '0;
                end else begin
                    acc_q  <= acc_sum;
                    ccnt_q <= ccnt_q + 1'b1;
                end
            end
        end
    end

    assign ncs          = ncs_q;
    assign sclk         = sclk_q;
    assign mosi         = mosi_q;
    assign raw_sample   = raw_q;
    assign offset       = offset_q;
    assign calibrating  = cal_q;
    assign sample_sign  = sign_q;
    assign sample_mag   = mag_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_adc_frontend.sv
// tb_adc_frontend: directed vectors and multi-cycle sequences for
// adc_frontend with a behavioural MCP3002-style ADC on the SPI pins.
module tb_adc_frontend;

    localparam int SP = 100;
    localparam int SH = 2;
    localparam int CL = 2;
    localparam int VLAT = 32 * SH + 2;
    localparam int FIRST = (1 << CL) * SP + VLAT;

    logic       clk;
    logic       reset;
    logic       start_cal;
    logic [9:0] gate_thresh;
    logic       miso;
    logic       sclk;
    logic       mosi;
    logic       ncs;
    logic [9:0] raw_sample;
    logic [9:0] offset;
    logic       calibrating;
    logic       sample_sign;
    logic [9:0] sample_mag;
    logic       sample_valid;

    adc_frontend #(
        .SAMPLE_PERIOD(SP),
        .SCLK_HALF(SH),
        .CAL_LOG2(CL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_cal(start_cal),
        .gate_thresh(gate_thresh),
        .miso(miso),
        .sclk(sclk),
        .mosi(mosi),
        .ncs(ncs),
        .raw_sample(raw_sample),
        .offset(offset),
        .calibrating(calibrating),
        .sample_sign(sample_sign),
        .sample_mag(sample_mag),
        .sample_valid(sample_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ADC model: counts sclk rising edges per burst, records the command
    // bits on edges 1..4, and presents B9..B0 for edges 6..15.
    logic [9:0] adc_val;
    logic [3:0] mosi_bits;
    int         e;

    initial begin
        miso = 1'b0;
        e = 0;
        mosi_bits = 4'd0;
    end

    always @(posedge ncs or negedge ncs) e = 0;

    always @(posedge sclk) begin
        if (!ncs) begin
            e = e + 1;
            if (e >= 1 && e <= 4)
                mosi_bits[4 - e] = mosi;
        end
    end

    always @(negedge sclk) begin
        if (!ncs && e >= 5 && e <= 14)
            miso = adc_val[14 - e];
    end

    int total;
    int passed;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_valid && n < 3 * SP);
        if (!sample_valid) begin
            total++;
            $display("FAIL %s: no sample_valid within %0d cycles", tag, n);
        end
    endtask

    // From reset release: cycles to the calibrating fall and first valid.
    task automatic run_cal(output int n, output int fall);
        n = 0;
        fall = 0;
        while (!sample_valid && n < 1000) begin
            @(negedge clk);
            n++;
            if (!calibrating && fall == 0)
                fall = n;
        end
    endtask

    typedef struct {
        logic [9:0] raw;
        logic [9:0] th;
        logic       sgn;
        logic [9:0] mag;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int fall;
        int lowc;
        int rises;
        int vc;
        int bad;
        int hi;
        int fall_idx;
        int valid_idx;
        logic prev_s;
        logic prev_n;

        total = 0;
        passed = 0;

        vecs[0] = '{10'h3FF, 10'd0,  1'b0, 10'h1FF};
        vecs[1] = '{10'h000, 10'd0,  1'b1, 10'h200};
        vecs[2] = '{10'h1FF, 10'd0,  1'b1, 10'h001};
        vecs[3] = '{10'h206, 10'd7,  1'b0, 10'h000};
        vecs[4] = '{10'h1FA, 10'd7,  1'b0, 10'h000};
        vecs[5] = '{10'h1F9, 10'd7,  1'b1, 10'h007};
        vecs[6] = '{10'h207, 10'd7,  1'b0, 10'h007};
        vecs[7] = '{10'h250, 10'h50, 1'b0, 10'h050};
        vecs[8] = '{10'h1B0, 10'h51, 1'b0, 10'h000};
        vecs[9] = '{10'h1B0, 10'h50, 1'b1, 10'h050};

        reset = 1'b1;
        start_cal = 1'b0;
        gate_thresh = 10'd0;
        adc_val = 10'h1F4;
        repeat (3) @(negedge clk);
        chk("rst_ncs", ncs, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_raw", raw_sample, 0);
        chk("rst_offset", offset, 10'h200);
        chk("rst_cal", calibrating, 1);
        chk("rst_sign", sample_sign, 0);
        chk("rst_mag", sample_mag, 0);
        chk("rst_valid", sample_valid, 0);

        // Calibration from reset with a constant 0x1F4 code.
        reset = 1'b0;
        run_cal(n, fall);
        chk("cal1_first_valid_cycle", n, FIRST);
        chk("cal1_fall_cycle", fall, FIRST - SP);
        chk("cal1_offset", offset, 10'h1F4);
        chk("cal1_sign", sample_sign, 0);
        chk("cal1_mag", sample_mag, 0);

        // Reset in the middle of the SPI burst (cnt 50, sclk high).
        repeat (SP - VLAT + 50) @(negedge clk);
        chk("mid_pre_ncs", ncs, 0);
        chk("mid_pre_sclk", sclk, 1);
        reset = 1'b1;
        #1;
        chk("mid_ncs", ncs, 1);
        chk("mid_sclk", sclk, 0);
        chk("mid_mosi", mosi, 0);
        chk("mid_raw", raw_sample, 0);
        chk("mid_offset", offset, 10'h200);
        chk("mid_cal", calibrating, 1);
        chk("mid_valid", sample_valid, 0);
        adc_val = 10'h200;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_cal(n, fall);
        chk("cal2_first_valid_cycle", n, FIRST);
        chk("cal2_fall_cycle", fall, FIRST - SP);
        chk("cal2_offset", offset, 10'h200);
        chk("cal2_mag", sample_mag, 0);

        // One full frame of SPI waveform, starting just after a valid.
        adc_val = 10'h2AA;
        mosi_bits = 4'd0;
        lowc = 0;
        rises = 0;
        vc = 0;
        fall_idx = -1;
        valid_idx = -1;
        prev_s = sclk;
        prev_n = ncs;
        for (int i = 1; i <= SP; i++) begin
            @(negedge clk);
            if (!ncs)
                lowc++;
            if (sclk && !prev_s)
                rises++;
            if (!ncs && prev_n && fall_idx < 0)
                fall_idx = i;
            if (sample_valid) begin
                vc++;
                valid_idx = i;
            end
            prev_s = sclk;
            prev_n = ncs;
        end
        chk("spi_ncs_low_cycles", lowc, 32 * SH);
        chk("spi_sclk_rises", rises, 16);
        chk("spi_mosi_cmd", mosi_bits, 4'b1101);
        chk("spi_valids_per_frame", vc, 1);
        chk("spi_valid_latency", valid_idx - fall_idx, VLAT);
        chk("spi_raw", raw_sample, 10'h2AA);
        chk("spi_sign", sample_sign, 0);
        chk("spi_mag", sample_mag, 10'h0AA);

        // Directed correction / gate vectors with offset 0x200.
        foreach (vecs[i]) begin
            adc_val = vecs[i].raw;
            gate_thresh = vecs[i].th;
            wait_valid($sformatf("vec%0d", i), n);
            chk($sformatf("vec%0d_period", i), n, SP);
            chk($sformatf("vec%0d_raw", i), raw_sample, vecs[i].raw);
            chk($sformatf("vec%0d_sign", i), sample_sign, vecs[i].sgn);
            chk($sformatf("vec%0d_mag", i), sample_mag, vecs[i].mag);
        end

        // Recalibration requested mid-run with the ADC moved to 0x180.
        gate_thresh = 10'd0;
        adc_val = 10'h180;
        start_cal = 1'b1;
        @(negedge clk);
        start_cal = 1'b0;
        chk("recal_not_yet", calibrating, 0);
        n = 0;
        while (!calibrating && n < 3 * SP) begin
            @(negedge clk);
            n++;
        end
        chk("recal_rise_delay", n, SP - VLAT - 1 + 1);
        hi = 0;
        vc = 0;
        bad = 0;
        while (calibrating && hi < 10 * SP) begin
            if (sample_valid)
                vc++;
            if (offset !== 10'h200)
                bad++;
            hi++;
            @(negedge clk);
        end
        chk("recal_high_cycles", hi, (1 << CL) * SP - SP + VLAT - 1);
        chk("recal_no_valids", vc, 0);
        chk("recal_offset_held", bad, 0);
        chk("recal_offset_new", offset, 10'h180);
        chk("recal_valid_at_fall", sample_valid, 0);
        wait_valid("recal_first", n);
        chk("recal_first_period", n, SP);
        chk("recal_first_sign", sample_sign, 0);
        chk("recal_first_mag", sample_mag, 0);
        adc_val = 10'h100;
        wait_valid("recal_next", n);
        chk("recal_next_sign", sample_sign, 1);
        chk("recal_next_mag", sample_mag, 10'h080);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
